// File: rtl/icache_fetch_requester_pkg.sv
// Shared constants, encodings and state type for the fetch requester.
package icache_fetch_requester_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'b00,
        PC_SEL_BRANCH = 2'b01,
        PC_SEL_JAL    = 2'b10,
        PC_SEL_JALR   = 2'b11
    } pc_select_e;

    typedef enum logic [1:0] {
        ST_REQ     = 2'b00,
        ST_WAIT    = 2'b01,
        ST_DISCARD = 2'b10
    } fetch_state_e;

    // Execute-stage redirect: jumps always, branches only when taken.
    function automatic logic is_redirect(input logic [1:0] sel, input logic branch_taken);
        return (sel == PC_SEL_JALR) | (sel == PC_SEL_JAL) | ((sel == PC_SEL_BRANCH) & branch_taken);
    endfunction

endpackage

// File: rtl/icache_fetch_requester_if.sv
// Instruction-cache request/response port; master is the fetch requester.
interface icache_fetch_requester_if #(
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DATA_WIDTH   = 32
);
    logic                    icache_req;
    logic [ADDRESS_BITS-1:0] icache_addr;
    logic                    icache_ready;
    logic                    icache_resp_valid;
    logic [DATA_WIDTH-1:0]   icache_resp_data;

    modport master (
        output icache_req,
        output icache_addr,
        input  icache_ready,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req,
        input  icache_addr,
        output icache_ready,
        output icache_resp_valid,
        output icache_resp_data
    );
endinterface

// File: rtl/icache_fetch_requester.sv
// Fetch front end: owns the PC, keeps one i-cache read in flight and
// presents the returned instruction as a one-entry slot to fetch_pipe.
module icache_fetch_requester
    import icache_fetch_requester_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              next_PC_select_execute,
    input  logic                    branch_execute,
    input  logic [ADDRESS_BITS-1:0] redirect_PC,
    icache_fetch_requester_if.master icache,
    output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
    output logic [DATA_WIDTH-1:0]   instruction_fetch,
    output logic                    icache_valid
);

    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_INST);

    fetch_state_e            state_q, state_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic [ADDRESS_BITS-1:0] slot_pc_q, slot_pc_d;
    logic [DATA_WIDTH-1:0]   slot_data_q, slot_data_d;
    logic                    slot_valid_q, slot_valid_d;

    logic redirect_c;
    logic req_c;
    logic handshake_c;

    assign redirect_c  = is_redirect(next_PC_select_execute, branch_execute);
    // Only request when the slot will be free to take the response.
    assign req_c       = (state_q == ST_REQ) & (~slot_valid_q | ~stall) & ~reset;
    assign handshake_c = req_c & icache.icache_ready;

    // Next-state: FSM transitions, PC update, slot fill/consume/flush.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_pc_d    = slot_pc_q;
        slot_data_d  = slot_data_q;
        slot_valid_d = slot_valid_q;

        if (slot_valid_q & ~stall) begin
            slot_valid_d = 1'b0;
            slot_pc_d    = '0;
            slot_data_d  = NOP_WORD;
        end

        if (redirect_c) begin
            slot_valid_d = 1'b0;
            slot_pc_d    = '0;
            slot_data_d  = NOP_WORD;
            pc_d         = redirect_PC;
            unique case (state_q)
                ST_REQ:     state_d = handshake_c ? ST_DISCARD : ST_REQ;
                ST_WAIT:    state_d = icache.icache_resp_valid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_d = icache.icache_resp_valid ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (handshake_c) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (icache.icache_resp_valid) begin
                        slot_valid_d = 1'b1;
                        slot_pc_d    = pc_q;
                        slot_data_d  = icache.icache_resp_data;
                        pc_d         = pc_q + ADDRESS_BITS'(4);
                        state_d      = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (icache.icache_resp_valid) state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            slot_pc_q    <= '0;
            slot_data_q  <= NOP_WORD;
            slot_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_pc_q    <= slot_pc_d;
            slot_data_q  <= slot_data_d;
            slot_valid_q <= slot_valid_d;
        end
    end

    assign icache.icache_req  = req_c;
    assign icache.icache_addr = pc_q;
    assign inst_PC_fetch      = slot_pc_q;
    assign instruction_fetch  = slot_data_q;
    assign icache_valid       = slot_valid_q;

endmodule

// File: tb/tb_icache_fetch_requester.sv
// Directed bench for icache_fetch_requester with hand-computed expectations.
module tb_icache_fetch_requester;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;

    logic          clock;
    logic          reset;
    logic          stall;
    logic [1:0]    next_PC_select_execute;
    logic          branch_execute;
    logic [AW-1:0] redirect_PC;
    logic [AW-1:0] inst_PC_fetch;
    logic [DW-1:0] instruction_fetch;
    logic          icache_valid;

    int total = 0;
    int bad   = 0;

    icache_fetch_requester_if #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW)) bus ();

    icache_fetch_requester #(
        .DATA_WIDTH  (DW),
        .ADDRESS_BITS(AW),
        .RESET_PC    ('0)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .next_PC_select_execute(next_PC_select_execute),
        .branch_execute        (branch_execute),
        .redirect_PC           (redirect_PC),
        .icache                (bus),
        .inst_PC_fetch         (inst_PC_fetch),
        .instruction_fetch     (instruction_fetch),
        .icache_valid          (icache_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [AW-1:0] pc, input logic [31:0] d);
        check_eq({tag, "_valid"}, 32'(icache_valid), 32'(v));
        check_eq({tag, "_pc"}, 32'(inst_PC_fetch), 32'(pc));
        check_eq({tag, "_data"}, instruction_fetch, d);
    endtask

    // One fetch against a cache that accepts immediately and answers one cycle later.
    task automatic cache_fetch(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.icache_ready = 1'b1;
        #1;
        check_eq("fetch_req", 32'(bus.icache_req), 32'd1);
        check_eq("fetch_addr", 32'(bus.icache_addr), 32'(addr));
        tick();
        bus.icache_ready      = 1'b0;
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = data;
        #1;
        check_eq("wait_req", 32'(bus.icache_req), 32'd0);
        tick();
        bus.icache_resp_valid = 1'b0;
        #1;
        check_slot("fill", 1'b1, addr, data);
    endtask

    initial begin
        reset                  = 1'b1;
        stall                  = 1'b0;
        next_PC_select_execute = 2'b00;
        branch_execute         = 1'b0;
        redirect_PC            = '0;
        bus.icache_ready       = 1'b1;
        bus.icache_resp_valid  = 1'b0;
        bus.icache_resp_data   = '0;

        // Reset state, request held low during reset.
        tick();
        check_eq("reset_req", 32'(bus.icache_req), 32'd0);
        tick();
        check_slot("reset", 1'b0, '0, 32'h0000_0013);
        reset = 1'b0;

        // Sequential fetches 0,4,8.
        cache_fetch(20'h00000, 32'hAAAA_0013);
        cache_fetch(20'h00004, 32'hAAAA_1013);
        cache_fetch(20'h00008, 32'hAAAA_2013);

        // Stall holds the slot and blocks requests.
        stall = 1'b1;
        bus.icache_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_req", 32'(bus.icache_req), 32'd0);
            tick();
            check_slot("stall_hold", 1'b1, 20'h00008, 32'hAAAA_2013);
        end
        stall = 1'b0;
        #1;
        check_eq("unstall_req", 32'(bus.icache_req), 32'd1);
        check_eq("unstall_addr", 32'(bus.icache_addr), 32'h0000C);
        cache_fetch(20'h0000C, 32'hAAAA_3013);

        // Redirect while a response is outstanding: stale data dropped.
        bus.icache_ready = 1'b1;
        #1;
        check_eq("pre_redir_addr", 32'(bus.icache_addr), 32'h00010);
        tick();
        bus.icache_ready       = 1'b0;
        next_PC_select_execute = 2'b10;
        redirect_PC            = 20'h00040;
        tick();
        next_PC_select_execute = 2'b00;
        #1;
        check_eq("discard_req", 32'(bus.icache_req), 32'd0);
        check_eq("discard_valid", 32'(icache_valid), 32'd0);
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.icache_resp_valid = 1'b0;
        #1;
        check_slot("dropped", 1'b0, '0, 32'h0000_0013);
        cache_fetch(20'h00040, 32'hBBBB_0013);

        // Branch not taken has no effect.
        stall                  = 1'b1;
        next_PC_select_execute = 2'b01;
        branch_execute         = 1'b0;
        redirect_PC            = 20'h00080;
        tick();
        check_slot("br_nt", 1'b1, 20'h00040, 32'hBBBB_0013);
        check_eq("br_nt_addr", 32'(bus.icache_addr), 32'h00044);

        // Branch taken flushes the slot and retargets the PC.
        branch_execute = 1'b1;
        tick();
        next_PC_select_execute = 2'b00;
        branch_execute         = 1'b0;
        stall                  = 1'b0;
        #1;
        check_slot("br_t", 1'b0, '0, 32'h0000_0013);
        check_eq("br_t_req", 32'(bus.icache_req), 32'd1);
        check_eq("br_t_addr", 32'(bus.icache_addr), 32'h00080);

        // Response and redirect in the same cycle: no DISCARD state.
        bus.icache_ready = 1'b1;
        tick();
        bus.icache_ready       = 1'b0;
        bus.icache_resp_valid  = 1'b1;
        bus.icache_resp_data   = 32'hCCCC_0013;
        next_PC_select_execute = 2'b11;
        redirect_PC            = 20'hFFFFC;
        tick();
        bus.icache_resp_valid  = 1'b0;
        next_PC_select_execute = 2'b00;
        #1;
        check_eq("same_cyc_valid", 32'(icache_valid), 32'd0);
        check_eq("same_cyc_req", 32'(bus.icache_req), 32'd1);
        check_eq("same_cyc_addr", 32'(bus.icache_addr), 32'hFFFFC);

        // Top-of-space fetch wraps the PC to zero.
        cache_fetch(20'hFFFFC, 32'hDDDD_0013);
        check_eq("wrap_addr", 32'(bus.icache_addr), 32'h00000);
        cache_fetch(20'h00000, 32'hEEEE_0013);

        // Reset while waiting returns to the reset PC.
        bus.icache_ready = 1'b1;
        #1;
        check_eq("pre_rst_addr", 32'(bus.icache_addr), 32'h00004);
        tick();
        bus.icache_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_wait_req", 32'(bus.icache_req), 32'd0);
        tick();
        reset = 1'b0;
        bus.icache_ready = 1'b1;
        #1;
        check_eq("post_rst_req", 32'(bus.icache_req), 32'd1);
        check_eq("post_rst_addr", 32'(bus.icache_addr), 32'h00000);
        check_slot("post_rst", 1'b0, '0, 32'h0000_0013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_fetch_requester.md
# icache_fetch_requester

Front end of the fetch stage: owns the program counter, issues single-outstanding read requests to the instruction cache, and presents each returned instruction with its PC as a one-entry valid/data slot to the fetch-to-decode pipe register. Handles execute-stage redirects by flushing the slot and discarding the stale in-flight response. Sits between the i-cache request/response port and `fetch_pipe` (which consumes `inst_PC_fetch`, `instruction_fetch`, `icache_valid`).

## Interface
- `DATA_WIDTH`, 32, instruction width
- `ADDRESS_BITS`, 20, PC/address width
- `RESET_PC`, 0, first fetch address after reset
- `clock`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  decode/fetch pipe holding; slot not consumed this cycle
- `next_PC_select_execute`  in  2  execute PC-select code
- `branch_execute`  in  1  branch taken (qualifies select 01)
- `redirect_PC`  in  ADDRESS_BITS  target address for redirects
- `icache_req`  out  1  request valid
- `icache_addr`  out  ADDRESS_BITS  request address (= PC)
- `icache_ready`  in  1  cache accepts request this cycle
- `icache_resp_valid`  in  1  response data valid (one cycle per request)
- `icache_resp_data`  in  DATA_WIDTH  instruction word
- `inst_PC_fetch`  out  ADDRESS_BITS  PC of slot instruction
- `instruction_fetch`  out  DATA_WIDTH  slot instruction
- `icache_valid`  out  1  slot holds a valid instruction

## Operation
- Redirect = select 11, or 10, or (01 and `branch_execute`). Redirect has priority over stall and response.
- States: REQ (request pending), WAIT (one accepted, response outstanding), DISCARD (stale response outstanding).
- REQ: `icache_req` = ~`icache_valid` | ~`stall` (slot empty or being consumed this edge); `icache_addr` = PC. Handshake = req & ready → WAIT.
- WAIT: on `icache_resp_valid` → slot <= {PC, data}, `icache_valid` <= 1, PC <= PC+4, → REQ.
- DISCARD: on `icache_resp_valid` drop data, → REQ; PC unchanged (already redirect target).
- Slot consumed at edge with `icache_valid` & ~`stall` and no new fill: `icache_valid` <= 0. Request gating guarantees slot is empty whenever a response is captured; response in WAIT with slot full is impossible by construction.
- Redirect at an edge: `icache_valid` <= 0, PC <= `redirect_PC`; next state: DISCARD if WAIT without response this cycle, DISCARD if handshake completes this cycle, DISCARD stays DISCARD (unless response this cycle → REQ), otherwise REQ. Response arriving in the redirect cycle is dropped.
- PC arithmetic modulo 2^ADDRESS_BITS; PC+4 wraps to 0 from top.
- Slot empty: `inst_PC_fetch` = 0, `instruction_fetch` = NOP 0x00000013.

## Timing
- Reset: state REQ, PC = `RESET_PC`, `icache_valid` 0, `inst_PC_fetch` 0, `instruction_fetch` NOP; `icache_req` forced 0 while `reset` high.
- First `icache_req` in cycle after reset deasserts.
- Latency: response at edge N → `icache_valid` high after edge N; next request in cycle after edge N (if slot consumable).
- Minimum response latency 1 cycle after acceptance; back-to-back hit cache gives one instruction per 2 cycles.
- Reset mid-WAIT/DISCARD: state returns to REQ; the cache is reset in the same cycle, so no stale response follows.
- `icache_addr` stable while `icache_req` high and ~`icache_ready`, unless a redirect occurs.

## Structure
- Shared package: NOP constant, PC_SELECT encodings (00 seq, 01 branch, 10 JAL, 11 JALR), state enum (REQ/WAIT/DISCARD).
- Single module; redirect decode is one combinational expression, no sub-module.

## Test plan
- Reset, cache ready with 1-cycle latency, data 0xAAAA0013 → `icache_addr` 0,4,8…; `icache_valid` pulses with PC 0,4,8 and matching data.
- Slot filled at PC 8, `stall` high 3 cycles → `icache_valid`/PC 8/data held; `icache_req` low until stall drops, then request addr 0xC.
- Request at 0x10 accepted, redirect (select 10, `redirect_PC` 0x40) before response → response dropped, next request addr 0x40, `icache_valid` stays 0.
- Redirect (select 01, `branch_execute` 0) → no effect; with `branch_execute` 1 → slot flushed, PC = target.
- Response and redirect (select 11) same cycle → response dropped, next request to `redirect_PC`, no DISCARD cycle.
- PC = 2^20−4 fetched → next `icache_addr` 0.
